// File: rtl/pl_mem_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - RV32I load/store funct3 encodings
//   - FSM state encoding for the memory handshake
//   - access-size decode helper used by the lane/alignment logic
package pl_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StErr  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SzByte = 2'b00,
        SzHalf = 2'b01,
        SzWord = 2'b10
    } size_e;

    // Unsupported encodings fall back to a full-word access.
    function automatic size_e access_size(input logic [2:0] f3, input logic store);
        size_e sz;
        sz = SzWord;
        if (store) begin
            case (f3)
                F3_SB:   sz = SzByte;
                F3_SH:   sz = SzHalf;
                default: sz = SzWord;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: sz = SzByte;
                F3_LH, F3_LHU: sz = SzHalf;
                default:       sz = SzWord;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/pl_mem_align.sv
// Combinational lane logic for the MEM stage.
//   store    : access is a store (otherwise a load)
//   func3    : RV32I funct3 of the access
//   off      : byte offset within the word (mal[1:0])
//   sdata    : store data (rs2)
//   rdata    : memory read data
//   be       : byte enables (all ones for loads)
//   wdata    : store data replicated onto every lane
//   ldata    : extracted and extended load data
//   misalign : access not naturally aligned for its size
module pl_mem_align
    import pl_mem_pkg::*;
(
    input  logic        store,
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misalign
);

    size_e       size;
    logic [31:0] byte_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        size      = access_size(func3, store);
        byte_word = rdata >> {off, 3'b000};
        byte_sel  = byte_word[7:0];
        // off[0] is zero for any half-word that actually reaches memory
        half_sel  = off[1] ? rdata[31:16] : rdata[15:0];

        be       = 4'b1111;
        wdata    = sdata;
        ldata    = rdata;
        misalign = 1'b0;

        case (size)
            SzByte: begin
                if (store) begin
                    be    = 4'b0001 << off;
                    wdata = {4{sdata[7:0]}};
                end
                // funct3[2] set selects the zero-extending variants
                ldata = func3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SzHalf: begin
                misalign = off[0];
                if (store) begin
                    be    = 4'b0011 << off;
                    wdata = {2{sdata[15:0]}};
                end
                ldata = func3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                misalign = |off;
            end
        endcase
    end

endmodule

// File: rtl/pl_mem_stage.sv
// MEM pipeline stage: drives the data-memory handshake, stalls the front of
// the pipeline while an access is outstanding and flags misaligned accesses
// and bus timeouts.
//   clk, clr                  : clock, asynchronous active-high reset
//   mwreg/mm2reg/mwmem/mrmem  : EX/MEM control
//   mfunc3/mal/mb/mrd         : access size, address, store data, dest reg
//   dmem_*                    : data-memory request/response
//   mm/wwreg_o/mm2reg_o       : to the MEM/WB register
//   mstall/misalign/bus_err   : pipeline stall and one-cycle error flags
module pl_mem_stage
    import pl_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic        mrmem,
    input  logic [2:0]  mfunc3,
    input  logic [31:0] mal,
    input  logic [31:0] mb,
    input  logic [4:0]  mrd,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    output logic [31:0] mm,
    output logic        wwreg_o,
    output logic        mm2reg_o,
    output logic        mstall,
    output logic        misalign,
    output logic        bus_err
);

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            valid;
    logic            mis_raw;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [31:0]     ldata;
    logic            unused_mrd;

    assign valid      = mrmem | mwmem;
    assign unused_mrd = ^mrd;

    pl_mem_align u_align (
        .store    (mwmem),
        .func3    (mfunc3),
        .off      (mal[1:0]),
        .sdata    (mb),
        .rdata    (dmem_rdata),
        .be       (be),
        .wdata    (wdata),
        .ldata    (ldata),
        .misalign (mis_raw)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt counts stall cycles already spent on the current access; the
    // transition to StErr fires on the cycle that would make it TIMEOUT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            StIdle: begin
                if (valid && !mis_raw && !dmem_ack) begin
                    cnt_d   = 1;
                    state_d = (TIMEOUT <= 1) ? StErr : StBusy;
                end
            end
            StBusy: begin
                if (dmem_ack) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_inc == CntMax) begin
                    state_d = StErr;
                    cnt_d   = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StErr: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // clr gates the outputs directly so a reset mid-access drops the request
    // in the same cycle rather than at the next edge.
    always_comb begin
        dmem_req = 1'b0;
        misalign = 1'b0;
        bus_err  = 1'b0;
        if (!clr) begin
            case (state_q)
                StIdle: begin
                    if (valid) begin
                        if (mis_raw) misalign = 1'b1;
                        else         dmem_req = 1'b1;
                    end
                end
                StBusy:  dmem_req = 1'b1;
                StErr:   bus_err  = 1'b1;
                default: ;
            endcase
        end
        mstall     = dmem_req & ~dmem_ack;
        wwreg_o    = mwreg & ~clr & ~misalign & ~bus_err;
        mm2reg_o   = mm2reg;
        mm         = (mrmem & ~mwmem) ? ldata : 32'd0;
        dmem_we    = mwmem;
        dmem_be    = be;
        dmem_wdata = wdata;
        dmem_addr  = {mal[31:2], 2'b00};
    end

endmodule

// File: tb/tb_pl_mem_stage.sv
// Self-checking bench for pl_mem_stage: directed scenarios followed by
// random accesses checked against a behavioural model.
module tb_pl_mem_stage;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        clr;
    logic        mwreg, mm2reg, mwmem, mrmem;
    logic [2:0]  mfunc3;
    logic [31:0] mal, mb;
    logic [4:0]  mrd;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] mm;
    logic        wwreg_o, mm2reg_o, mstall, misalign, bus_err;

    int n_vec = 0;
    int n_err = 0;

    // Captured observations of the last access, for directed checks
    int          obs_stall;
    logic [31:0] obs_mm, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_wwreg, obs_berr, obs_mis, obs_req;

    pl_mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .clr        (clr),
        .mwreg      (mwreg),
        .mm2reg     (mm2reg),
        .mwmem      (mwmem),
        .mrmem      (mrmem),
        .mfunc3     (mfunc3),
        .mal        (mal),
        .mb         (mb),
        .mrd        (mrd),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .mm         (mm),
        .wwreg_o    (wwreg_o),
        .mm2reg_o   (mm2reg_o),
        .mstall     (mstall),
        .misalign   (misalign),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int acc_bytes(input logic [2:0] f3, input logic st);
        if (st) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] al,
                                               input logic [31:0] rdata);
        int n;
        longint unsigned v;
        logic sgn;
        n = acc_bytes(f3, 1'b0);
        if (n == 4) return rdata;
        v = rdata;
        v = (v >> (8 * (al % 4))) % (64'd1 << (8 * n));
        sgn = (f3 == 3'b000) || (f3 == 3'b001);
        if (sgn && v >= (64'd1 << (8 * n - 1))) v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] al,
                                            input logic st);
        int n;
        int m;
        if (!st) return 4'hF;
        n = acc_bytes(f3, 1'b1);
        m = ((1 << n) - 1) << (al % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] b);
        int n;
        n = acc_bytes(f3, 1'b1);
        if (n == 1) return (b & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (b & 32'hFFFF) * 32'h0001_0001;
        return b;
    endfunction

    // Runs one EX/MEM instruction to completion. Entered and left #1 after a
    // rising edge; waits = cycles before ack (>= TIMEOUT means no ack ever).
    task automatic run_access(input logic wr, input logic rdv, input logic wreg, input logic m2r,
                              input logic [2:0] f3, input logic [31:0] al, input logic [31:0] b,
                              input logic [31:0] rdata, input int waits);
        logic        valid, mis, is_load;
        int          n, nw;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        valid   = wr | rdv;
        is_load = rdv & ~wr;
        n       = acc_bytes(f3, wr);
        mis     = valid && ((al % n) != 0);
        e_be    = model_be(f3, al, wr);
        e_wd    = model_wdata(f3, b);

        mwmem = wr; mrmem = rdv; mwreg = wreg; mm2reg = m2r;
        mfunc3 = f3; mal = al; mb = b; mrd = 5'($urandom);
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        obs_stall = 0;

        if (!valid || mis) begin
            @(negedge clk);
            check_eq("req_idle", 32'(dmem_req), 32'd0);
            check_eq("stall_idle", 32'(mstall), 32'd0);
            check_eq("misalign", 32'(misalign), 32'(mis));
            check_eq("bus_err_idle", 32'(bus_err), 32'd0);
            check_eq("wwreg_idle", 32'(wwreg_o), mis ? 32'd0 : 32'(wreg));
            check_eq("mm2reg", 32'(mm2reg_o), 32'(m2r));
            if (!valid) check_eq("mm_nonmem", mm, 32'd0);
            obs_mis = misalign; obs_req = dmem_req; obs_wwreg = wwreg_o; obs_berr = bus_err;
            if (mstall) obs_stall++;
            @(posedge clk); #1;
            return;
        end

        nw = (waits >= int'(TIMEOUT)) ? int'(TIMEOUT) : waits;
        for (int i = 0; i < nw; i++) begin
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            @(negedge clk);
            check_eq("req_wait", 32'(dmem_req), 32'd1);
            check_eq("stall_wait", 32'(mstall), 32'd1);
            check_eq("addr_wait", dmem_addr, {al[31:2], 2'b00});
            check_eq("we_wait", 32'(dmem_we), 32'(wr));
            check_eq("be_wait", 32'(dmem_be), 32'(e_be));
            if (wr) check_eq("wdata_wait", dmem_wdata, e_wd);
            check_eq("bus_err_wait", 32'(bus_err), 32'd0);
            check_eq("misalign_wait", 32'(misalign), 32'd0);
            if (mstall) obs_stall++;
            @(posedge clk); #1;
        end

        if (waits < int'(TIMEOUT)) begin
            dmem_ack = 1'b1; dmem_rdata = rdata;
            @(negedge clk);
            check_eq("req_ack", 32'(dmem_req), 32'd1);
            check_eq("stall_ack", 32'(mstall), 32'd0);
            check_eq("addr_ack", dmem_addr, {al[31:2], 2'b00});
            check_eq("we_ack", 32'(dmem_we), 32'(wr));
            check_eq("be_ack", 32'(dmem_be), 32'(e_be));
            if (wr) check_eq("wdata_ack", dmem_wdata, e_wd);
            if (is_load) check_eq("mm_ack", mm, model_load(f3, al, rdata));
            check_eq("wwreg_ack", 32'(wwreg_o), 32'(wreg));
            check_eq("bus_err_ack", 32'(bus_err), 32'd0);
        end else begin
            dmem_ack = 1'b0;
            @(negedge clk);
            check_eq("req_err", 32'(dmem_req), 32'd0);
            check_eq("bus_err", 32'(bus_err), 32'd1);
            check_eq("wwreg_err", 32'(wwreg_o), 32'd0);
            check_eq("stall_err", 32'(mstall), 32'd0);
        end
        if (mstall) obs_stall++;
        obs_mm = mm; obs_be = dmem_be; obs_wdata = dmem_wdata;
        obs_wwreg = wwreg_o; obs_berr = bus_err; obs_mis = misalign; obs_req = dmem_req;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
    endtask

    initial begin
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [31:0] al;
        int          n, r, w;

        // Reset with a valid access presented: all outputs must stay quiet
        clr = 1'b1;
        mwreg = 1'b1; mm2reg = 1'b0; mwmem = 1'b0; mrmem = 1'b1;
        mfunc3 = 3'b010; mal = 32'h100; mb = '0; mrd = '0;
        dmem_rdata = '0; dmem_ack = 1'b0;
        #2;
        check_eq("rst_req", 32'(dmem_req), 32'd0);
        check_eq("rst_stall", 32'(mstall), 32'd0);
        check_eq("rst_wwreg", 32'(wwreg_o), 32'd0);
        check_eq("rst_misalign", 32'(misalign), 32'd0);
        check_eq("rst_bus_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;

        // LB, zero-wait
        run_access(1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0);
        check_eq("lb_mm", obs_mm, 32'hFFFF_FF80);
        check_eq("lb_stall", 32'(obs_stall), 32'd0);
        check_eq("lb_wwreg", 32'(obs_wwreg), 32'd1);

        // SH, three wait states
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 32'h202, 32'h0000_BEEF, 32'h0, 3);
        check_eq("sh_be", 32'(obs_be), 32'hC);
        check_eq("sh_wdata", obs_wdata, 32'hBEEF_BEEF);
        check_eq("sh_stall", 32'(obs_stall), 32'd3);

        // LW misaligned
        run_access(1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 32'h101, 32'h0, 32'h0, 0);
        check_eq("lw_mis_flag", 32'(obs_mis), 32'd1);
        check_eq("lw_mis_req", 32'(obs_req), 32'd0);
        check_eq("lw_mis_wwreg", 32'(obs_wwreg), 32'd0);
        check_eq("lw_mis_stall", 32'(obs_stall), 32'd0);

        // LHU upper half
        run_access(1'b0, 1'b1, 1'b1, 1'b1, 3'b101, 32'h002, 32'h0, 32'hA5A5_1234, 1);
        check_eq("lhu_mm", obs_mm, 32'h0000_A5A5);

        // Load that never gets an ack
        run_access(1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 32'h400, 32'h0, 32'h0, 1000);
        check_eq("to_stall", 32'(obs_stall), 32'(TIMEOUT));
        check_eq("to_bus_err", 32'(obs_berr), 32'd1);
        check_eq("to_wwreg", 32'(obs_wwreg), 32'd0);
        run_access(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 0);
        check_eq("to_idle_stall", 32'(obs_stall), 32'd0);

        // Reset on the second BUSY cycle
        mwmem = 1'b0; mrmem = 1'b1; mwreg = 1'b1; mfunc3 = 3'b010; mal = 32'h800;
        dmem_ack = 1'b0;
        @(posedge clk); #1;   // first BUSY cycle
        @(posedge clk); #1;   // second BUSY cycle
        check_eq("pre_clr_req", 32'(dmem_req), 32'd1);
        clr = 1'b1;
        #1;
        check_eq("clr_req_async", 32'(dmem_req), 32'd0);
        check_eq("clr_stall_async", 32'(mstall), 32'd0);
        check_eq("clr_wwreg", 32'(wwreg_o), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        mrmem = 1'b0; mwreg = 1'b0;
        #1;
        check_eq("post_clr_req", 32'(dmem_req), 32'd0);
        check_eq("post_clr_stall", 32'(mstall), 32'd0);
        check_eq("post_clr_mis", 32'(misalign), 32'd0);
        check_eq("post_clr_berr", 32'(bus_err), 32'd0);
        check_eq("post_clr_wwreg", 32'(wwreg_o), 32'd0);
        @(posedge clk); #1;
        // Idle with a cleared counter: a TIMEOUT-1 wait must still complete
        run_access(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h804, 32'h0, 32'h1234_5678, TIMEOUT - 1);
        check_eq("post_clr_stall_cnt", 32'(obs_stall), 32'(TIMEOUT - 1));
        check_eq("post_clr_mm", obs_mm, 32'h1234_5678);

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            op = 2'($urandom_range(0, 3));
            f3 = 3'($urandom_range(0, 7));
            al = $urandom;
            n  = acc_bytes(f3, op[1]);
            if ($urandom_range(0, 3) != 0) al = al - (al % n);
            r = $urandom_range(0, 9);
            if (r < 7)      w = $urandom_range(0, 3);
            else if (r < 9) w = $urandom_range(4, TIMEOUT - 1);
            else            w = $urandom_range(TIMEOUT, TIMEOUT + 2);
            run_access(op[1], op[0], 1'($urandom), 1'($urandom), f3, al, $urandom, $urandom, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
